// File: rtl/mem_arbiter_2to1_if.sv
// Mem_ift: request/reply interface with independent read and write channels.
// Master drives requests and reply_ready; Slave drives request_ready and replies.
interface Mem_ift #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  read_request_valid;
    logic                  read_request_ready;
    logic [ADDR_WIDTH-1:0] read_request_addr;
    logic                  read_reply_valid;
    logic                  read_reply_ready;
    logic [DATA_WIDTH-1:0] read_reply_data;
    logic [1:0]            read_reply_resp;

    logic                  write_request_valid;
    logic                  write_request_ready;
    logic [ADDR_WIDTH-1:0] write_request_addr;
    logic [DATA_WIDTH-1:0] write_request_data;
    logic                  write_reply_valid;
    logic                  write_reply_ready;
    logic [1:0]            write_reply_resp;

    modport Master (
        output read_request_valid, read_request_addr, read_reply_ready,
        output write_request_valid, write_request_addr, write_request_data, write_reply_ready,
        input  read_request_ready, read_reply_valid, read_reply_data, read_reply_resp,
        input  write_request_ready, write_reply_valid, write_reply_resp
    );

    modport Slave (
        input  read_request_valid, read_request_addr, read_reply_ready,
        input  write_request_valid, write_request_addr, write_request_data, write_reply_ready,
        output read_request_ready, read_reply_valid, read_reply_data, read_reply_resp,
        output write_request_ready, write_reply_valid, write_reply_resp
    );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// Two-master to one-slave Mem_ift arbiter; read and write channels arbitrated independently.
// MEM_ARB_RR_EN defined: round-robin on contention; undefined: master0 has fixed priority.
module mem_arbiter_2to1 (
    input  logic   clk,
    input  logic   rstn,
    Mem_ift.Slave  master0,
    Mem_ift.Slave  master1,
    Mem_ift.Master slave0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state, w_state;
    logic   r_gnt, r_last;
    logic   w_gnt, w_last;

    // Winner when leaving IDLE; the final fallback is never taken since IDLE only
    // calls this with at least one master valid.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
`ifdef MEM_ARB_RR_EN
        if (v0 && v1) return ~last;
`else
        if (v0 && v1) return 1'b0;
`endif
        return v0 ? 1'b0 : (v1 ? 1'b1 : last);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                IDLE: if (master0.read_request_valid || master1.read_request_valid) begin
                    r_gnt   <= pick(master0.read_request_valid, master1.read_request_valid, r_last);
                    r_state <= REQ;
                end
                REQ: if (slave0.read_request_valid && slave0.read_request_ready) begin
                    r_last  <= r_gnt;
                    r_state <= RESP;
                end
                RESP: if (slave0.read_reply_valid && slave0.read_reply_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= IDLE;
            w_gnt   <= 1'b0;
            w_last  <= 1'b1;
        end else begin
            case (w_state)
                IDLE: if (master0.write_request_valid || master1.write_request_valid) begin
                    w_gnt   <= pick(master0.write_request_valid, master1.write_request_valid, w_last);
                    w_state <= REQ;
                end
                REQ: if (slave0.write_request_valid && slave0.write_request_ready) begin
                    w_last  <= w_gnt;
                    w_state <= RESP;
                end
                RESP: if (slave0.write_reply_valid && slave0.write_reply_ready) w_state <= IDLE;
                default: w_state <= IDLE;
            endcase
        end
    end

    // Read channel routing: the grant register selects which master is connected.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        slave0.read_request_valid  = 1'b0;
        slave0.read_request_addr   = '0;
        slave0.read_reply_ready    = 1'b0;
        master0.read_request_ready = 1'b0;
        master0.read_reply_valid   = 1'b0;
        master0.read_reply_data    = '0;
        master0.read_reply_resp    = '0;
        master1.read_request_ready = 1'b0;
        master1.read_reply_valid   = 1'b0;
        master1.read_reply_data    = '0;
        master1.read_reply_resp    = '0;
        case (r_state)
            REQ: begin
                if (r_gnt) begin
                    slave0.read_request_valid  = master1.read_request_valid;
                    slave0.read_request_addr   = master1.read_request_addr;
                    master1.read_request_ready = slave0.read_request_ready;
                end else begin
                    slave0.read_request_valid  = master0.read_request_valid;
                    slave0.read_request_addr   = master0.read_request_addr;
                    master0.read_request_ready = slave0.read_request_ready;
                end
            end
            RESP: begin
                if (r_gnt) begin
                    master1.read_reply_valid = slave0.read_reply_valid;
                    master1.read_reply_data  = slave0.read_reply_data;
                    master1.read_reply_resp  = slave0.read_reply_resp;
                    slave0.read_reply_ready  = master1.read_reply_ready;
                end else begin
                    master0.read_reply_valid = slave0.read_reply_valid;
                    master0.read_reply_data  = slave0.read_reply_data;
                    master0.read_reply_resp  = slave0.read_reply_resp;
                    slave0.read_reply_ready  = master0.read_reply_ready;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        slave0.write_request_valid  = 1'b0;
        slave0.write_request_addr   = '0;
        slave0.write_request_data   = '0;
        slave0.write_reply_ready    = 1'b0;
        master0.write_request_ready = 1'b0;
        master0.write_reply_valid   = 1'b0;
        master0.write_reply_resp    = '0;
        master1.write_request_ready = 1'b0;
        master1.write_reply_valid   = 1'b0;
        master1.write_reply_resp    = '0;
        case (w_state)
            REQ: begin
                if (w_gnt) begin
                    slave0.write_request_valid  = master1.write_request_valid;
                    slave0.write_request_addr   = master1.write_request_addr;
                    slave0.write_request_data   = master1.write_request_data;
                    master1.write_request_ready = slave0.write_request_ready;
                end else begin
                    slave0.write_request_valid  = master0.write_request_valid;
                    slave0.write_request_addr   = master0.write_request_addr;
                    slave0.write_request_data   = master0.write_request_data;
                    master0.write_request_ready = slave0.write_request_ready;
                end
            end
            RESP: begin
                if (w_gnt) begin
                    master1.write_reply_valid = slave0.write_reply_valid;
                    master1.write_reply_resp  = slave0.write_reply_resp;
                    slave0.write_reply_ready  = master1.write_reply_ready;
                end else begin
                    master0.write_reply_valid = slave0.write_reply_valid;
                    master0.write_reply_resp  = slave0.write_reply_resp;
                    slave0.write_reply_ready  = master0.write_reply_ready;
                end
            end
            default: ;
        endcase
    end

endmodule
